asi_master_tx: RTL and testbench

AS-i master-request transmitter that consumes the 3 us half-bit clock from the 3 us clock divider.
- The divider output is not used as a clock. It is sampled in the clk_in domain, and each of its edges becomes a one-cycle half-bit tick.
- On a start request the block latches SB/address/information, generates even parity, and Manchester-encodes the 14-bit master request onto tx_out (6 us per bit).
- After the frame it enforces an idle pause, then reports completion.

---
 rtl/asi_master_tx_if.sv | 22 ++
 rtl/asi_master_tx.sv | 133 +++++++++++++
 tb/tb_asi_master_tx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/asi_master_tx_if.sv
// Handshake, frame-field and line signals of the AS-i master-request transmitter.
interface asi_master_tx_if;
  logic       clk_3us;
  logic       start;
  logic       sb;
  logic [4:0] addr;
  logic [4:0] info;
  logic       tx_out;
  logic       tx_en;
  logic       busy;
  logic       done;

  modport master (
    input  clk_3us, start, sb, addr, info,
    output tx_out, tx_en, busy, done
  );

  modport slave (
    output clk_3us, start, sb, addr, info,
    input  tx_out, tx_en, busy, done
  );
endinterface

// File: rtl/asi_master_tx.sv
// AS-i master-request transmitter: latches SB/address/info, adds even parity and
// Manchester-encodes the 14-bit frame on half-bit ticks derived from the 3 us divider.
module asi_master_tx #(
  parameter logic        IDLE_LEVEL   = 1'b1,
  parameter int unsigned PAUSE_HALVES = 2
) (
  input logic             clk_in,
  input logic             rst,
  asi_master_tx_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  localparam logic [4:0] LAST_HALF = 5'd27;
  localparam logic [3:0] PAUSE_CNT = 4'(PAUSE_HALVES);

  logic [1:0]  state_q, state_d;
  logic        clk3_q;
  logic        tick;
  logic [13:0] frame_q, frame_d;
  logic [4:0]  half_q, half_d;
  logic [3:0]  pause_q, pause_d;
  logic        tx_out_q, tx_out_d;
  logic        tx_en_q, tx_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  half_nxt;
  logic [3:0]  pause_nxt;

  // Even half-bits carry the inverted bit, odd half-bits the bit itself.
  function automatic logic half_level(input logic [13:0] fr, input logic [4:0] idx);
    logic b;
    b = fr[4'd13 - idx[4:1]];
    return idx[0] ? b : ~b;
  endfunction

  assign tick      = bus.clk_3us ^ clk3_q;
  assign half_nxt  = half_q + 5'd1;
  assign pause_nxt = pause_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    half_d   = half_q;
    pause_d  = pause_q;
    tx_out_d = tx_out_q;
    tx_en_d  = tx_en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start arriving while done is still high belongs to the old frame and is dropped.
        if (bus.start && !done_q) begin
          frame_d = {1'b0, bus.sb, bus.addr, bus.info, ^{bus.sb, bus.addr, bus.info}, 1'b1};
          busy_d  = 1'b1;
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (tick) begin
          tx_en_d  = 1'b1;
          tx_out_d = half_level(frame_q, 5'd0);
          half_d   = 5'd0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (tick) begin
          if (half_q == LAST_HALF) begin
            tx_en_d  = 1'b0;
            tx_out_d = IDLE_LEVEL;
            pause_d  = 4'd0;
            if (PAUSE_CNT == 4'd0) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_PAUSE;
            end
          end else begin
            half_d   = half_nxt;
            tx_out_d = half_level(frame_q, half_nxt);
          end
        end
      end
      S_PAUSE: begin
        if (tick) begin
          pause_d = pause_nxt;
          if (pause_nxt == PAUSE_CNT) begin
            pause_d = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      clk3_q   <= 1'b0;
      frame_q  <= 14'd0;
      half_q   <= 5'd0;
      pause_q  <= 4'd0;
      tx_out_q <= IDLE_LEVEL;
      tx_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk3_q   <= bus.clk_3us;
      frame_q  <= frame_d;
      half_q   <= half_d;
      pause_q  <= pause_d;
      tx_out_q <= tx_out_d;
      tx_en_q  <= tx_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.tx_out = tx_out_q;
  assign bus.tx_en  = tx_en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_asi_master_tx.sv
// Randomized bench for asi_master_tx: frames are checked cycle by cycle against a
// field/parity/Manchester model, including sync alignment, pause length, ignored starts and abort.
`timescale 1ns/1ps
module tb_asi_master_tx;

  localparam int PAUSE_HALVES = 2;
  localparam int HALF_CYC     = 18;

  logic clk_in = 1'b0;
  logic rst;
  asi_master_tx_if bus();

  asi_master_tx #(
    .IDLE_LEVEL  (1'b1),
    .PAUSE_HALVES(PAUSE_HALVES)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  int   testCount = 0;
  int   failCount = 0;
  int   divCnt    = 0;
  logic tog       = 1'b0;
  logic prevTog   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clk_in cycle; also emulates the 3 us divider (toggle every 18 cycles, 0 in reset).
  task automatic step();
    @(posedge clk_in);
    #1;
    prevTog = tog;
    if (!rst) begin
      bus.clk_3us = 1'b0;
      divCnt      = 0;
      tog         = 1'b0;
    end else if (divCnt == HALF_CYC - 1) begin
      divCnt      = 0;
      bus.clk_3us = ~bus.clk_3us;
      tog         = 1'b1;
    end else begin
      divCnt++;
      tog = 1'b0;
    end
  endtask

  function automatic logic [13:0] modelFrame(input logic s, input logic [4:0] a, input logic [4:0] i);
    int ones;
    ones = int'(s) + $countones(a) + $countones(i);
    return {1'b0, s, a, i, 1'(ones % 2), 1'b1};
  endfunction

  function automatic logic modelHalf(input logic [13:0] fr, input int h);
    logic b;
    b = fr[13 - h / 2];
    return (h % 2 == 0) ? ~b : b;
  endfunction

  task automatic applyStimulus(input logic s, input logic [4:0] a, input logic [4:0] i);
    bus.sb    = s;
    bus.addr  = a;
    bus.info  = i;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.sb    = 1'($urandom);
    bus.addr  = 5'($urandom);
    bus.info  = 5'($urandom);
  endtask

  // mode 0: plain frame, 1: start on a tick, 2: stray starts in SEND/PAUSE/done cycle, 3: abort by reset
  task automatic runFrame(input logic s, input logic [4:0] a, input logic [4:0] i, input int mode);
    logic [13:0] fr;
    logic [31:0] obsLvl, obsEn;
    logic        badL, badE, busyDrop, seenDone;
    int          lat, pc;
    fr = modelFrame(s, a, i);
    if (mode == 1) begin
      lat = 0;
      while (!tog && lat < 40) begin
        step();
        lat++;
      end
    end
    applyStimulus(s, a, i);
    checkOutput("busy_on_accept", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.tx_en && lat < 40) begin
      step();
      lat++;
    end
    checkOutput("tx_en_rise", 32'(bus.tx_en), 32'd1);
    if (!bus.tx_en) return;
    checkOutput("rise_on_tick", 32'(prevTog), 32'd1);
    if (mode == 1) checkOutput("sync_latency", 32'(lat), 32'd18);
    else           checkOutput("sync_latency_range", 32'(lat >= 1 && lat <= 18), 32'd1);

    for (int h = 0; h < 28; h++) begin
      badL = 1'b0;
      badE = 1'b0;
      obsLvl = 32'(bus.tx_out);
      obsEn  = 32'({bus.tx_en, bus.busy, bus.done});
      for (int c = 0; c < HALF_CYC; c++) begin
        if (!badL && bus.tx_out !== modelHalf(fr, h)) begin
          badL   = 1'b1;
          obsLvl = 32'(bus.tx_out);
        end
        if (!badE && {bus.tx_en, bus.busy, bus.done} !== 3'b110) begin
          badE  = 1'b1;
          obsEn = 32'({bus.tx_en, bus.busy, bus.done});
        end
        if (mode == 3 && h == 13 && c == 5) begin
          rst = 1'b0;
          step();
          checkOutput("abort_outputs", 32'({bus.tx_out, bus.tx_en, bus.busy, bus.done}), 32'b1000);
          rst = 1'b1;
          seenDone = 1'b0;
          for (int k = 0; k < 60; k++) begin
            step();
            if (bus.done || bus.busy || bus.tx_en) seenDone = 1'b1;
          end
          checkOutput("abort_quiet", 32'(seenDone), 32'd0);
          return;
        end
        if (mode == 2 && h == 10 && c == 3) bus.start = 1'b1;
        step();
        bus.start = 1'b0;
      end
      checkOutput($sformatf("halfbit%0d", h), obsLvl, 32'(modelHalf(fr, h)));
      checkOutput($sformatf("en_busy%0d", h), obsEn, 32'b110);
    end
    checkOutput("tx_en_fall", 32'({bus.tx_en, bus.tx_out, bus.busy}), 32'b011);

    pc = 0;
    busyDrop = 1'b0;
    while (!bus.done && pc < 100) begin
      if (bus.busy !== 1'b1 || bus.tx_en !== 1'b0) busyDrop = 1'b1;
      if (mode == 2 && pc == 10) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      pc++;
    end
    checkOutput("pause_len", 32'(pc), 32'(PAUSE_HALVES * HALF_CYC));
    checkOutput("busy_in_pause", 32'(busyDrop), 32'd0);
    checkOutput("busy_at_done", 32'({bus.done, bus.busy}), 32'b10);
    if (mode == 2) bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checkOutput("after_done", 32'({bus.done, bus.busy, bus.tx_en}), 32'b000);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       rs;
    logic [4:0] ra, ri;
    rst         = 1'b0;
    bus.clk_3us = 1'b0;
    bus.start   = 1'b0;
    bus.sb      = 1'b0;
    bus.addr    = 5'd0;
    bus.info    = 5'd0;
    repeat (3) step();
    checkOutput("reset_state", 32'({bus.tx_out, bus.tx_en, bus.busy, bus.done}), 32'b1000);
    rst = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      checkOutput($sformatf("idle%0d", k), 32'({bus.tx_out, bus.tx_en, bus.busy, bus.done}), 32'b1000);
    end

    runFrame(1'b0, 5'b10101, 5'b00011, 0);
    runFrame(1'b1, 5'b11111, 5'b11111, 0);
    runFrame(1'b0, 5'b00000, 5'b00000, 0);

    rs = 1'($urandom); ra = 5'($urandom); ri = 5'($urandom);
    runFrame(rs, ra, ri, 2);
    rs = 1'($urandom); ra = 5'($urandom); ri = 5'($urandom);
    runFrame(rs, ra, ri, 0);

    rs = 1'($urandom); ra = 5'($urandom); ri = 5'($urandom);
    runFrame(rs, ra, ri, 3);
    rs = 1'($urandom); ra = 5'($urandom); ri = 5'($urandom);
    runFrame(rs, ra, ri, 0);

    rs = 1'($urandom); ra = 5'($urandom); ri = 5'($urandom);
    runFrame(rs, ra, ri, 1);

    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 25)) step();
      rs = 1'($urandom); ra = 5'($urandom); ri = 5'($urandom);
      runFrame(rs, ra, ri, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
